// File: rtl/pipe_adc_scan_if.sv
// ADC handshake bundle between the scan controller (master) and the
// external converter (slave).
interface pipe_adc_scan_if #(
    parameter int CH_W = 2
);
    logic            adc_start;
    logic [CH_W-1:0] adc_ch;
    logic            adc_done;
    logic [7:0]      adc_data;

    modport master (
        output adc_start,
        output adc_ch,
        input  adc_done,
        input  adc_data
    );

    modport slave (
        input  adc_start,
        input  adc_ch,
        output adc_done,
        output adc_data
    );
endinterface

// File: rtl/pipe_adc_scan_ctrl.sv
// Round-robin ADC scan scheduler for NUM_CH pipe temperature sensors.
// Each captured sample classifies its channel as NORMAL / ALARM / SHUTDOWN and
// drives per-channel alarm flags plus a global shutdown.
// Optional macro PIPE_SCAN_DEBOUNCE_EN: a channel only changes class after two
// consecutive samples agree on the new class (timeout samples act at once).
//
// state   | meaning
// IDLE    | scanning stopped, channel index retained
// START   | one-cycle adc_start, timeout counter cleared
// WAIT    | waiting for adc_done or timeout
// CAPTURE | sample_valid pulse, channel class updated
// NEXT    | advance channel, resume or stop on scan_en
module pipe_adc_scan_ctrl #(
    parameter int NUM_CH   = 4,
    parameter int CH_W     = 2,
    parameter int ALARM_TH = 192,
    parameter int TIMEOUT  = 15
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_scan_en,
    pipe_adc_scan_if.master      adc_if,
    output logic                 o_sample_valid,
    output logic [CH_W-1:0]      o_sample_ch,
    output logic [7:0]           o_sample_data,
    output logic [NUM_CH-1:0]    o_alarm,
    output logic                 o_shutdown,
    output logic                 o_adc_fault
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT,
        ST_CAPTURE,
        ST_NEXT
    } state_t;

    typedef enum logic [1:0] {
        CLS_NORMAL = 2'd0,
        CLS_ALARM  = 2'd1,
        CLS_SHUT   = 2'd2
    } cls_t;

    localparam logic [7:0]      LP_ALARM_TH = 8'(ALARM_TH);
    // The last WAIT cycle is the one in which the counter still reads TIMEOUT-1.
    localparam logic [3:0]      LP_TO_LAST  = 4'(TIMEOUT - 1);
    localparam logic [CH_W-1:0] LP_CH_LAST  = CH_W'(NUM_CH - 1);

    state_t          r_state;
    logic [CH_W-1:0] r_ch;
    logic [3:0]      r_cnt;
    logic            r_adc_start;
    cls_t            r_cls [NUM_CH];
    cls_t            w_cls_next [NUM_CH];
    cls_t            w_new_cls;
    logic [NUM_CH-1:0] w_alarm_next;
    logic            w_shut_next;

`ifdef PIPE_SCAN_DEBOUNCE_EN
    logic            r_is_to;
    cls_t            r_pend [NUM_CH];
    cls_t            w_pend_next [NUM_CH];
`endif

    assign adc_if.adc_start = r_adc_start;
    assign adc_if.adc_ch    = r_ch;

    // Scan sequencer: conversion handshake, timeout and sample capture.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state        <= ST_IDLE;
            r_ch           <= '0;
            r_cnt          <= '0;
            r_adc_start    <= 1'b0;
            o_sample_valid <= 1'b0;
            o_sample_ch    <= '0;
            o_sample_data  <= '0;
            o_adc_fault    <= 1'b0;
`ifdef PIPE_SCAN_DEBOUNCE_EN
            r_is_to        <= 1'b0;
`endif
        end else begin
            r_adc_start    <= 1'b0;
            o_sample_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_scan_en) begin
                        r_state     <= ST_START;
                        r_adc_start <= 1'b1;
                    end
                end
                ST_START: begin
                    r_cnt   <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (adc_if.adc_done) begin
                        o_sample_valid <= 1'b1;
                        o_sample_ch    <= r_ch;
                        o_sample_data  <= adc_if.adc_data;
                        r_state        <= ST_CAPTURE;
`ifdef PIPE_SCAN_DEBOUNCE_EN
                        r_is_to        <= 1'b0;
`endif
                    end else if (r_cnt == LP_TO_LAST) begin
                        r_cnt          <= r_cnt + 4'd1;
                        o_sample_valid <= 1'b1;
                        o_sample_ch    <= r_ch;
                        o_sample_data  <= 8'hFF;
                        o_adc_fault    <= 1'b1;
                        r_state        <= ST_CAPTURE;
`ifdef PIPE_SCAN_DEBOUNCE_EN
                        r_is_to        <= 1'b1;
`endif
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                ST_CAPTURE: begin
                    r_state <= ST_NEXT;
                end
                ST_NEXT: begin
                    r_ch <= (r_ch == LP_CH_LAST) ? '0 : r_ch + CH_W'(1);
                    if (i_scan_en) begin
                        r_state     <= ST_START;
                        r_adc_start <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Next channel classes; only the captured channel can change, and only in CAPTURE.
    always_comb begin
        if (o_sample_data == 8'hFF) begin
            w_new_cls = CLS_SHUT;
        end else if (o_sample_data >= LP_ALARM_TH) begin
            w_new_cls = CLS_ALARM;
        end else begin
            w_new_cls = CLS_NORMAL;
        end
        for (int i = 0; i < NUM_CH; i++) begin
            w_cls_next[i] = r_cls[i];
`ifdef PIPE_SCAN_DEBOUNCE_EN
            w_pend_next[i] = r_pend[i];
`endif
        end
        if (r_state == ST_CAPTURE) begin
`ifdef PIPE_SCAN_DEBOUNCE_EN
            w_pend_next[r_ch] = w_new_cls;
            if (r_is_to) begin
                w_cls_next[r_ch] = CLS_SHUT;
            end else if (r_pend[r_ch] == w_new_cls) begin
                w_cls_next[r_ch] = w_new_cls;
            end
`else
            w_cls_next[r_ch] = w_new_cls;
`endif
        end
        w_shut_next = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_alarm_next[i] = (w_cls_next[i] == CLS_ALARM);
            w_shut_next     = w_shut_next | (w_cls_next[i] == CLS_SHUT);
        end
    end

    // Channel class storage and registered protection outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_cls[i] <= CLS_NORMAL;
`ifdef PIPE_SCAN_DEBOUNCE_EN
                r_pend[i] <= CLS_NORMAL;
`endif
            end
            o_alarm    <= '0;
            o_shutdown <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_cls[i] <= w_cls_next[i];
`ifdef PIPE_SCAN_DEBOUNCE_EN
                r_pend[i] <= w_pend_next[i];
`endif
            end
            o_alarm    <= w_alarm_next;
            o_shutdown <= w_shut_next;
        end
    end

endmodule

// File: tb/tb_pipe_adc_scan_ctrl.sv
// Directed + randomized bench for pipe_adc_scan_ctrl with a per-channel class model.
module tb_pipe_adc_scan_ctrl;

    logic       clk;
    logic       reset;
    logic       scan_en;
    logic       sample_valid;
    logic [1:0] sample_ch;
    logic [7:0] sample_data;
    logic [3:0] alarm;
    logic       shutdown;
    logic       adc_fault;

    pipe_adc_scan_if #(.CH_W(2)) adc_if ();

    pipe_adc_scan_ctrl #(
        .NUM_CH(4), .CH_W(2), .ALARM_TH(192), .TIMEOUT(15)
    ) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_scan_en      (scan_en),
        .adc_if         (adc_if.master),
        .o_sample_valid (sample_valid),
        .o_sample_ch    (sample_ch),
        .o_sample_data  (sample_data),
        .o_alarm        (alarm),
        .o_shutdown     (shutdown),
        .o_adc_fault    (adc_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // reference model: class per channel (0 normal, 1 alarm, 2 shutdown)
    int m_cls  [4];
    int m_prev [4];
    bit m_fault;
    int exp_ch;
    int last_wait;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic int classify(input logic [7:0] v);
        if (v == 8'd255) return 2;
        if (v >= 8'd192) return 1;
        return 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_cls[i]  = 0;
            m_prev[i] = -1;
        end
        m_fault = 0;
        exp_ch  = 0;
    endtask

    task automatic model_sample(input int ch, input logic [7:0] v, input bit to);
        int c;
        c = classify(v);
`ifdef PIPE_SCAN_DEBOUNCE_EN
        if (to || m_prev[ch] == c) m_cls[ch] = c;
        m_prev[ch] = c;
`else
        m_cls[ch] = c;
`endif
        if (to) m_fault = 1;
    endtask

    function automatic logic [3:0] model_alarm();
        logic [3:0] a;
        for (int i = 0; i < 4; i++) a[i] = (m_cls[i] == 1);
        return a;
    endfunction

    function automatic logic model_shut();
        logic s;
        s = 1'b0;
        for (int i = 0; i < 4; i++) s = s | (m_cls[i] == 2);
        return s;
    endfunction

    function automatic logic [7:0] rnd_data();
        case ($urandom_range(0, 4))
            0: return 8'($urandom_range(0, 190));
            1: return 8'($urandom_range(192, 254));
            2: return 8'd255;
            3: return 8'd191;
            default: return 8'd192;
        endcase
    endfunction

    // One full conversion, starting from IDLE or NEXT; ends in the NEXT cycle.
    task automatic do_conv(input int delay, input logic [7:0] data, input bit to, input bit drop_en);
        bit got;
        logic [7:0] exp_data;
        got = 0;
        last_wait = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (adc_if.adc_start === 1'b1) begin
                got = 1;
                break;
            end
            last_wait++;
        end
        check("start_seen", 32'(got), 32'd1);
        if (!got) return;
        check("adc_ch_start", 32'(adc_if.adc_ch), 32'(exp_ch));
        if (drop_en) scan_en = 1'b0;
        tick();
        check("start_one_cycle", 32'(adc_if.adc_start), 32'd0);
        if (to) begin
            repeat (14) tick();
            check("no_early_timeout", 32'(sample_valid), 32'd0);
            tick();
        end else begin
            repeat (delay - 1) tick();
            adc_if.adc_done = 1'b1;
            adc_if.adc_data = data;
            tick();
            adc_if.adc_done = 1'b0;
            adc_if.adc_data = 8'h00;
        end
        exp_data = to ? 8'd255 : data;
        check("sample_valid", 32'(sample_valid), 32'd1);
        check("sample_ch", 32'(sample_ch), 32'(exp_ch));
        check("sample_data", 32'(sample_data), 32'(exp_data));
        check("adc_ch_hold", 32'(adc_if.adc_ch), 32'(exp_ch));
        model_sample(exp_ch, exp_data, to);
        tick();
        check("sample_pulse", 32'(sample_valid), 32'd0);
        check("alarm", 32'(alarm), 32'(model_alarm()));
        check("shutdown", 32'(shutdown), 32'(model_shut()));
        check("adc_fault", 32'(adc_fault), 32'(m_fault));
        exp_ch = (exp_ch + 1) % 4;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_start"}, 32'(adc_if.adc_start), 32'd0);
        check({tag, "_ch"}, 32'(adc_if.adc_ch), 32'd0);
        check({tag, "_valid"}, 32'(sample_valid), 32'd0);
        check({tag, "_sdata"}, 32'(sample_data), 32'd0);
        check({tag, "_alarm"}, 32'(alarm), 32'd0);
        check({tag, "_shut"}, 32'(shutdown), 32'd0);
        check({tag, "_fault"}, 32'(adc_fault), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        logic [3:0] deb_tbl;
        logic [7:0] deb_seq [4];
        reset = 1'b1;
        scan_en = 1'b0;
        adc_if.adc_done = 1'b0;
        adc_if.adc_data = 8'h00;
        model_reset();
        repeat (3) tick();
        check_all_zero("reset");
        reset = 1'b0;
        repeat (3) tick();
        check("idle_no_start", 32'(adc_if.adc_start), 32'd0);

        // stray done in IDLE is ignored
        adc_if.adc_done = 1'b1;
        adc_if.adc_data = 8'd255;
        tick();
        adc_if.adc_done = 1'b0;
        check("idle_done_ignored", 32'(sample_valid), 32'd0);
        tick();
        check("idle_done_no_shut", 32'(shutdown), 32'd0);

        // basic round-robin with value 100, done after 3 WAIT cycles
        scan_en = 1'b1;
        do_conv(3, 8'd100, 0, 0);
        check("start_latency", 32'(last_wait), 32'd0);
        repeat (4) do_conv(3, 8'd100, 0, 0);

        // ch2 walks ALARM -> SHUTDOWN -> NORMAL
        while (exp_ch != 2) do_conv(2, 8'd100, 0, 0);
        do_conv(3, 8'd200, 0, 0);
        repeat (3) do_conv(1, 8'd100, 0, 0);
        do_conv(3, 8'd255, 0, 0);
        repeat (3) do_conv(1, 8'd100, 0, 0);
        do_conv(3, 8'd50, 0, 0);

        // timeout on ch1, done in the very last WAIT cycle still wins
        while (exp_ch != 1) do_conv(1, 8'd100, 0, 0);
        do_conv(0, 8'd0, 1, 0);
        do_conv(15, 8'd10, 0, 0);

        // randomized traffic
        repeat (24) do_conv($urandom_range(1, 15), rnd_data(), ($urandom_range(0, 7) == 0), 0);

        // stop during WAIT on ch3, resume at ch0
        while (exp_ch != 3) do_conv(1, 8'd100, 0, 0);
        do_conv(4, 8'd120, 0, 1);
        tick();
        check("stopped_idle", 32'(adc_if.adc_start), 32'd0);
        tick();
        check("stopped_idle2", 32'(adc_if.adc_start), 32'd0);
        scan_en = 1'b1;
        do_conv(2, 8'd100, 0, 0);
        check("resume_latency", 32'(last_wait), 32'd0);

        // reset during WAIT, late done dropped
        do_conv(0, 8'd0, 1, 0);
        tick();
        check("restart_seen", 32'(adc_if.adc_start), 32'd1);
        tick();
        tick();
        reset = 1'b1;
        scan_en = 1'b0;
        tick();
        reset = 1'b0;
        model_reset();
        adc_if.adc_done = 1'b1;
        adc_if.adc_data = 8'd255;
        tick();
        adc_if.adc_done = 1'b0;
        adc_if.adc_data = 8'h00;
        check_all_zero("midreset");
        tick();
        check_all_zero("midreset_after");

        // ch0 sequence 200,100,200,200 with fillers on other channels
        deb_seq[0] = 8'd200;
        deb_seq[1] = 8'd100;
        deb_seq[2] = 8'd200;
        deb_seq[3] = 8'd200;
`ifdef PIPE_SCAN_DEBOUNCE_EN
        deb_tbl = 4'b1000;
`else
        deb_tbl = 4'b1101;
`endif
        scan_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            do_conv(2, deb_seq[k], 0, 0);
            check("deb_alarm0", 32'(alarm[0]), 32'(deb_tbl[k]));
            repeat (3) do_conv(1, 8'd30, 0, 0);
        end
        scan_en = 1'b0;
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
